// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Stage 1 forms bit and 4-bit group generate/propagate terms. Stage 2 resolves the
// group and bit carries and registers the sum and flags.
module cla_adder_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NumGroups = int'(WIDTH) / 4;

    if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_width_check
        $error("cla_adder_pipe: WIDTH must be a multiple of 4 and at least 4");
    end

    // Handshake
    logic adv1, adv2, ld1, ld2;

    // Stage-1 combinational terms
    logic [WIDTH-1:0]     b_eff, p_in, g_in;
    logic                 c0_in;
    logic [NumGroups-1:0] gg_in, gp_in;

    // Stage-1 registers
    logic                 s1_valid_d, s1_valid_q;
    logic [WIDTH-1:0]     p_d, p_q, g_d, g_q;
    logic [NumGroups-1:0] gg_d, gg_q, gp_d, gp_q;
    logic                 c0_d, c0_q;

    // Stage-2 combinational carries and results
    logic [NumGroups:0]   gc;
    logic [WIDTH:0]       c;
    logic [WIDTH-1:0]     sum_c;
    logic                 cout_c, ovf_c, zero_c;
    logic                 unused_g_top;

    // Stage-2 registers
    logic                 out_valid_d, out_valid_q;
    logic [WIDTH-1:0]     sum_d, sum_q;
    logic                 cout_d, cout_q, ovf_d, ovf_q, zero_d, zero_q;

    // Advance conditions: a stage may load when it is empty or its content moves on.
    always_comb begin
        adv2     = ~out_valid_q | out_ready;
        adv1     = ~s1_valid_q | adv2;
        in_ready = adv1;
        ld1      = adv1 & in_valid;
        ld2      = adv2 & s1_valid_q;
    end

    // Operand conditioning plus bit and group generate/propagate.
    always_comb begin
        b_eff = sub ? ~b : b;
        c0_in = sub ? ~cin : cin;
        g_in  = a & b_eff;
        p_in  = a ^ b_eff;
        gg_in = '0;
        gp_in = '0;
        for (int k = 0; k < NumGroups; k++) begin
            gg_in[k] = g_in[4*k+3]
                     | (p_in[4*k+3] & g_in[4*k+2])
                     | (p_in[4*k+3] & p_in[4*k+2] & g_in[4*k+1])
                     | (p_in[4*k+3] & p_in[4*k+2] & p_in[4*k+1] & g_in[4*k]);
            gp_in[k] = p_in[4*k+3] & p_in[4*k+2] & p_in[4*k+1] & p_in[4*k];
        end
    end

    // Group carries as a flattened sum of products, so no group waits on its neighbour.
    always_comb begin
        logic term;
        logic acc;
        term  = 1'b0;
        acc   = 1'b0;
        gc    = '0;
        gc[0] = c0_q;
        for (int k = 0; k < NumGroups; k++) begin
            term = c0_q;
            for (int m = 0; m <= k; m++) begin
                term = term & gp_q[m];
            end
            acc = term;
            for (int j = 0; j <= k; j++) begin
                term = gg_q[j];
                for (int m = j + 1; m <= k; m++) begin
                    term = term & gp_q[m];
                end
                acc = acc | term;
            end
            gc[k+1] = acc;
        end
    end

    // Bit carries inside each group from the group carry-in.
    always_comb begin
        c            = '0;
        unused_g_top = 1'b0;
        for (int k = 0; k < NumGroups; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g_q[4*k] | (p_q[4*k] & gc[k]);
            c[4*k+2] = g_q[4*k+1]
                     | (p_q[4*k+1] & g_q[4*k])
                     | (p_q[4*k+1] & p_q[4*k] & gc[k]);
            c[4*k+3] = g_q[4*k+2]
                     | (p_q[4*k+2] & g_q[4*k+1])
                     | (p_q[4*k+2] & p_q[4*k+1] & g_q[4*k])
                     | (p_q[4*k+2] & p_q[4*k+1] & p_q[4*k] & gc[k]);
            // Top generate bit of a group only matters through GG, already captured.
            unused_g_top = unused_g_top ^ g_q[4*k+3];
        end
        c[WIDTH] = gc[NumGroups];
    end

    // Sum and flags from the resolved carries.
    always_comb begin
        sum_c  = p_q ^ c[WIDTH-1:0];
        cout_c = c[WIDTH];
        ovf_c  = c[WIDTH] ^ c[WIDTH-1];
        zero_c = ~|sum_c;
    end

    // Next state: valids follow their stage advance; data holds unless a valid beat loads.
    always_comb begin
        s1_valid_d  = adv1 ? in_valid : s1_valid_q;
        p_d         = p_q;
        g_d         = g_q;
        gg_d        = gg_q;
        gp_d        = gp_q;
        c0_d        = c0_q;
        if (ld1) begin
            p_d  = p_in;
            g_d  = g_in;
            gg_d = gg_in;
            gp_d = gp_in;
            c0_d = c0_in;
        end
        out_valid_d = adv2 ? s1_valid_q : out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        if (ld2) begin
            sum_d  = sum_c;
            cout_d = cout_c;
            ovf_d  = ovf_c;
            zero_d = zero_c;
        end
    end

    // Pipeline registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            p_q         <= '0;
            g_q         <= '0;
            gg_q        <= '0;
            gp_q        <= '0;
            c0_q        <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            p_q         <= p_d;
            g_q         <= g_d;
            gg_q        <= gg_d;
            gp_q        <= gp_d;
            c0_q        <= c0_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Self-checking bench for cla_adder_pipe at WIDTH = 4, 16 and 32 driven in lockstep.
module tb_cla_adder_pipe;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
    } beat_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a32, b32;
    logic        cin, sub;

    logic        in_ready_w  [3];
    logic        out_valid_w [3];
    logic        cout_w      [3];
    logic        ovf_w       [3];
    logic        zero_w      [3];
    logic [3:0]  sum4;
    logic [15:0] sum16;
    logic [31:0] sum32;
    logic [31:0] res_w       [3];

    int          checks = 0;
    int          errors = 0;
    beat_t       q[$];
    logic        held;
    logic [31:0] held_res    [3];
    logic        held_co     [3];
    logic        held_ov     [3];
    logic        held_z      [3];
    logic        last_acc;
    logic        stall_seen;
    int          fired;
    vec_t        vecs        [8];

    cla_adder_pipe #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_w[0]),
        .a         (a32[3:0]),
        .b         (b32[3:0]),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid_w[0]),
        .out_ready (out_ready),
        .sum       (sum4),
        .cout      (cout_w[0]),
        .ovf       (ovf_w[0]),
        .zero      (zero_w[0])
    );

    cla_adder_pipe #(.WIDTH(16)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_w[1]),
        .a         (a32[15:0]),
        .b         (b32[15:0]),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid_w[1]),
        .out_ready (out_ready),
        .sum       (sum16),
        .cout      (cout_w[1]),
        .ovf       (ovf_w[1]),
        .zero      (zero_w[1])
    );

    cla_adder_pipe #(.WIDTH(32)) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_w[2]),
        .a         (a32),
        .b         (b32),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid_w[2]),
        .out_ready (out_ready),
        .sum       (sum32),
        .cout      (cout_w[2]),
        .ovf       (ovf_w[2]),
        .zero      (zero_w[2])
    );

    assign res_w[0] = {28'd0, sum4};
    assign res_w[1] = {16'd0, sum16};
    assign res_w[2] = sum32;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int width_of(input int w);
        return (w == 0) ? 4 : ((w == 1) ? 16 : 32);
    endfunction

    // Reference: plain integer arithmetic on the effective operands.
    function automatic void model(input int w, input beat_t bt, output logic [31:0] s,
                                  output logic co, output logic ov, output logic z);
        longint m, aa, bb, c0, full, half, sa, sb, ss;
        m    = (longint'(1) << w) - 1;
        aa   = longint'(bt.a) & m;
        bb   = bt.sub ? (~longint'(bt.b)) & m : longint'(bt.b) & m;
        c0   = (bt.sub ? !bt.cin : bt.cin) ? 1 : 0;
        full = aa + bb + c0;
        s    = 32'(full & m);
        co   = ((full >> w) & 1) != 0;
        half = longint'(1) << (w - 1);
        sa   = (aa >= half) ? aa - 2 * half : aa;
        sb   = (bb >= half) ? bb - 2 * half : bb;
        ss   = sa + sb + c0;
        ov   = (ss >= half) || (ss < -half);
        z    = (s == 32'd0);
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One beat at full throughput; checks exact 2-cycle latency on the 16-bit instance.
    task automatic send_check(input vec_t v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a32       = {16'd0, v.a};
        b32       = {16'd0, v.b};
        cin       = v.cin;
        sub       = v.sub;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk1("lat_not_early", out_valid_w[1], 1'b0);
        @(posedge clk); #1;
        chk1("lat_valid", out_valid_w[1], 1'b1);
        chk32("vec_sum", res_w[1], {16'd0, v.s});
        chk1("vec_cout", cout_w[1], v.co);
        chk1("vec_ovf", ovf_w[1], v.ov);
        chk1("vec_zero", zero_w[1], v.z);
    endtask

    // Mid-cycle observation of the handshake against the in-flight queue.
    task automatic mon();
        logic        exp_rdy;
        logic [31:0] es;
        logic        eco, eov, ez;
        beat_t       bt;
        exp_rdy = (q.size() < 2) || out_ready;
        for (int w = 0; w < 3; w++) chk1("in_ready", in_ready_w[w], exp_rdy);
        if (!in_ready_w[1]) stall_seen = 1'b1;
        if (held) begin
            for (int w = 0; w < 3; w++) begin
                chk1("stall_valid", out_valid_w[w], 1'b1);
                chk32("stall_sum", res_w[w], held_res[w]);
                chk1("stall_cout", cout_w[w], held_co[w]);
                chk1("stall_ovf", ovf_w[w], held_ov[w]);
                chk1("stall_zero", zero_w[w], held_z[w]);
            end
        end
        if (out_valid_w[1] && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_beat: got out_valid 1 expected none in flight");
            end else begin
                bt = q.pop_front();
                fired++;
                for (int w = 0; w < 3; w++) begin
                    model(width_of(w), bt, es, eco, eov, ez);
                    chk1("rnd_valid", out_valid_w[w], 1'b1);
                    chk32("rnd_sum", res_w[w], es);
                    chk1("rnd_cout", cout_w[w], eco);
                    chk1("rnd_ovf", ovf_w[w], eov);
                    chk1("rnd_zero", zero_w[w], ez);
                end
            end
        end
        last_acc = in_valid && in_ready_w[1];
        if (last_acc) q.push_back('{a: a32, b: b32, cin: cin, sub: sub});
        held = out_valid_w[1] && !out_ready;
        for (int w = 0; w < 3; w++) begin
            held_res[w] = res_w[w];
            held_co[w]  = cout_w[w];
            held_ov[w]  = ovf_w[w];
            held_z[w]   = zero_w[w];
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        mon();
        @(posedge clk); #1;
    endtask

    initial begin
        int idx;
        int accepted;
        int cyc;

        vecs[0] = '{16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        a32        = '0;
        b32        = '0;
        cin        = 1'b0;
        sub        = 1'b0;
        held       = 1'b0;
        last_acc   = 1'b0;
        stall_seen = 1'b0;
        fired      = 0;

        // Reset held with live random traffic.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            a32       = $urandom;
            b32       = $urandom;
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            in_valid  = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
        end
        #1;
        for (int w = 0; w < 3; w++) begin
            chk1("rst_out_valid", out_valid_w[w], 1'b0);
            chk1("rst_in_ready", in_ready_w[w], 1'b1);
        end
        chk32("rst_sum", res_w[1], 32'd0);
        chk1("rst_cout", cout_w[1], 1'b0);
        chk1("rst_ovf", ovf_w[1], 1'b0);
        chk1("rst_zero", zero_w[1], 1'b0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 8; i++) send_check(vecs[i]);

        // Reset with two beats in flight.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        a32       = 32'd1;
        b32       = 32'd1;
        cin       = 1'b0;
        sub       = 1'b0;
        @(posedge clk); #1;
        a32 = 32'd2;
        b32 = 32'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk1("mid_full_valid", out_valid_w[1], 1'b1);
        chk1("mid_full_ready", in_ready_w[1], 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk1("mid_rst_valid", out_valid_w[1], 1'b0);
        chk32("mid_rst_sum", res_w[1], 32'd0);
        chk1("mid_rst_ready", in_ready_w[1], 1'b1);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk1("mid_gone1", out_valid_w[1], 1'b0);
        @(posedge clk); #1;
        chk1("mid_gone2", out_valid_w[1], 1'b0);
        send_check(vecs[6]);

        // Drain the last directed beat before queue-tracked phases.
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        held = 1'b0;

        // Backpressure: 8 back-to-back beats, consumer stalled in cycles 3-6.
        idx = 0;
        cyc = 1;
        while ((idx < 8 || q.size() != 0) && cyc < 40) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            in_valid  = (idx < 8);
            a32       = 32'h0001_1000 * idx + 32'(idx);
            b32       = 32'h0F0F_0F0F ^ 32'(idx * 7);
            cin       = idx[0];
            sub       = idx[1];
            cycle();
            if (last_acc) idx++;
            cyc++;
        end
        chk1("bp_stall_seen", stall_seen, 1'b1);
        chk32("bp_all_out", 32'(fired), 32'd8);

        // Randomised traffic with random valid/ready.
        accepted = 0;
        cyc      = 0;
        while (accepted < 10000 && cyc < 40000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a32       = $urandom;
            b32       = $urandom;
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            cycle();
            if (last_acc) accepted++;
            cyc++;
        end
        chk32("rnd_accepted", 32'(accepted), 32'd10000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() != 0; i++) cycle();
        chk32("drain_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
